fir_filter: RTL and testbench

- Synchronous N-tap direct-form FIR filter on signed two's-complement samples.
- Accepts one input sample every clock cycle and produces one filtered sample every clock cycle.
- Coefficients are fixed at elaboration time through a parameter.
- Sits in the sample datapath between a sample source and downstream DSP logic; there is no handshake, and every clock edge is a sample.

---
 rtl/fir_filter.sv | 42 ++++
 tb/tb_fir_filter.sv | 84 ++++++++
 2 files changed

// File: rtl/fir_filter.sv
// fir_filter: direct-form N-tap FIR with round-half-up scaling and output saturation
module fir_filter #(
  parameter int N = 4,
  parameter int WIDTH = 16,
  parameter logic [N*WIDTH-1:0] COEFFS = 64'h0004_0003_0002_0001,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Xn,
  output logic [WIDTH-1:0] Yn
);
  localparam int AW = 2*WIDTH + $clog2(N) + 1;
  localparam int RND = SHIFT > 0 ? 2**(SHIFT-1) : 0;
  localparam logic signed [AW-1:0] MAXV = AW'((2**(WIDTH-1)) - 1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
  logic signed [WIDTH-1:0] d_q [N-1];
  logic signed [WIDTH-1:0] t [N];
  logic signed [AW-1:0] acc, acc_r;
  logic [WIDTH-1:0] y_d, y_q;
  always_comb begin
    t[0] = signed'(Xn);
    for (int k = 1; k < N; k++) t[k] = d_q[k-1];
    acc = '0;
    for (int k = 0; k < N; k++)
      acc = acc + AW'(signed'(COEFFS[k*WIDTH +: WIDTH])) * AW'(t[k]);
    acc_r = (acc + AW'(RND)) >>> SHIFT;
    y_d = acc_r > MAXV ? MAXV[WIDTH-1:0] : acc_r < MINV ? MINV[WIDTH-1:0] : acc_r[WIDTH-1:0];
  end
  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N-1; k++) d_q[k] <= '0;
      y_q <= '0;
    end else begin
      d_q[0] <= signed'(Xn);
      for (int k = 1; k < N-1; k++) d_q[k] <= d_q[k-1];
      y_q <= y_d;
    end
  end
  assign Yn = y_q;
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed test-plan sequences plus randomized stimulus against a history-based model
module tb_fir_filter;
  logic clk = 0, rst = 1;
  logic signed [15:0] x = 0, y0, y1;
  int tests = 0, fails = 0;
  int hist[$];
  always #5 clk = ~clk;
  fir_filter dut0 (.clk(clk), .rst_n(rst), .Xn(x), .Yn(y0));
  fir_filter #(.SHIFT(1)) dut1 (.clk(clk), .rst_n(rst), .Xn(x), .Yn(y1));
  function automatic int model(int sh);
    longint acc = 0;
    for (int k = 0; k < 4 && k < hist.size(); k++) acc += longint'(k + 1) * hist[k];
    if (sh > 0) acc = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
    return acc > 32767 ? 32767 : acc < -32768 ? -32768 : int'(acc);
  endfunction
  task automatic check(string tag, int got, int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(int xv, bit r);
    @(negedge clk);
    x = 16'(xv);
    rst = r;
    @(posedge clk);
    #1;
    if (r) hist.delete();
    else begin
      hist.push_front(xv);
      if (hist.size() > 4) void'(hist.pop_back());
    end
    check("model_s0", int'(y0), model(0));
    check("model_s1", int'(y1), model(1));
  endtask
  initial begin
    int dx[9] = '{100, 200, -50, 25, 0, 0, 0, 0, 0};
    int dy[9] = '{100, 400, 650, 925, 700, -125, 100, 0, 0};
    int iy[5] = '{1, 2, 3, 4, 0};
    int ry[5] = '{2, 3, 5, 6, 0};
    step(0, 1);
    step(0, 1);
    check("reset", int'(y0), 0);
    step(0, 0);
    check("post_reset", int'(y0), 0);
    for (int i = 0; i < 9; i++) begin
      step(dx[i], 0);
      check("default_seq", int'(y0), dy[i]);
    end
    for (int i = 0; i < 5; i++) begin
      step(i == 0 ? 1 : 0, 0);
      check("impulse", int'(y0), iy[i]);
    end
    for (int i = 0; i < 6; i++) begin
      step(32767, 0);
      check("sat_pos", int'(y0), 32767);
    end
    step(0, 1);
    for (int i = 0; i < 6; i++) begin
      step(-32768, 0);
      check("sat_neg", int'(y0), -32768);
    end
    step(0, 1);
    step(100, 0);
    step(200, 0);
    step(77, 1);
    check("mid_reset_edge", int'(y0), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      check("mid_reset_after", int'(y0), 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(i == 0 ? 3 : 0, 0);
      check("round_s1", int'(y1), ry[i]);
    end
    for (int i = 0; i < 400; i++)
      step(int'($urandom_range(0, 65535)) - 32768, $urandom_range(0, 31) == 0);
    for (int i = 0; i < 200; i++)
      step(int'($urandom_range(0, 400)) - 200, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
